// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
// Runs a W_SLICE*N_SLICES-bit operation through an external combinational
// W_SLICE-bit ALU, one slice per clock, LSB slice first, and presents the
// assembled result with a valid/ready handshake.
// Optional feature: define ALU_SEQ_ZERO_EN to add a registered Zero flag
// that is set when the completed result is all zeros.
module alu_slice_sequencer #(
  parameter int W_SLICE  = 4,
  parameter int N_SLICES = 4
) (
  input  logic                          Clk,
  input  logic                          nReset,
  input  logic                          In_valid,
  output logic                          In_ready,
  input  logic [W_SLICE*N_SLICES-1:0]   OpA,
  input  logic [W_SLICE*N_SLICES-1:0]   OpB,
  input  logic                          Cin,
  input  logic [2:0]                    OpMode,
  output logic [W_SLICE-1:0]            AluA,
  output logic [W_SLICE-1:0]            AluB,
  output logic                          AluCB_in,
  output logic [2:0]                    AluMode,
  input  logic [W_SLICE-1:0]            AluResult,
  input  logic                          AluCB_out,
  output logic                          Out_valid,
  input  logic                          Out_ready,
  output logic [W_SLICE*N_SLICES-1:0]   Res,
  output logic                          Cout
`ifdef ALU_SEQ_ZERO_EN
  ,
  output logic                          Zero
`endif
);

  localparam int W   = W_SLICE * N_SLICES;
  localparam int K_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [K_W-1:0]       r_k;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [W-1:0]         r_res;
  logic                 r_cout;

  // Latched request and working accumulator (no reset: only read in RUN)
  logic [W-1:0]         r_opa;
  logic [W-1:0]         r_opb;
  logic                 r_cin;
  logic [2:0]           r_mode;
  logic [W-1:0]         r_acc;
  logic                 r_carry;

  logic                 w_run;
  logic                 w_arith;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_cb_in;
  logic [W_SLICE-1:0]   w_slice_a;
  logic [W_SLICE-1:0]   w_slice_b;
  logic [W-1:0]         w_acc_nxt;

  assign w_run    = (r_state == RUN);
  assign w_arith  = (r_mode[2:1] == 2'b00);
  assign w_last   = (r_k == K_LAST);
  assign w_accept = (r_state == IDLE) && In_valid;

  // Select the current operand slices and merge the ALU result into slice k
  always_comb begin
    w_slice_a = '0;
    w_slice_b = '0;
    w_acc_nxt = r_acc;
    for (int i = 0; i < N_SLICES; i++) begin
      if (r_k == K_W'(i)) begin
        w_slice_a = r_opa[i*W_SLICE +: W_SLICE];
        w_slice_b = r_opb[i*W_SLICE +: W_SLICE];
        w_acc_nxt[i*W_SLICE +: W_SLICE] = AluResult;
      end
    end
  end

  // Carry chain only for add/subtract; first slice takes the request carry
  assign w_cb_in = w_arith ? ((r_k == '0) ? r_cin : r_carry) : 1'b0;

  // ALU drive is forced to zero outside RUN (including while in reset)
  assign AluA     = w_run ? w_slice_a : '0;
  assign AluB     = w_run ? w_slice_b : '0;
  assign AluCB_in = w_run ? w_cb_in   : 1'b0;
  assign AluMode  = w_run ? r_mode    : 3'b000;

  assign In_ready  = r_in_ready;
  assign Out_valid = r_out_valid;
  assign Res       = r_res;
  assign Cout      = r_cout;

  // Capture the request on acceptance and accumulate slices while running
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_opa  <= OpA;
      r_opb  <= OpB;
      r_cin  <= Cin;
      r_mode <= OpMode;
    end
    if (w_run) begin
      r_acc   <= w_acc_nxt;
      r_carry <= AluCB_out;
    end
  end

`ifdef ALU_SEQ_ZERO_EN
  logic r_zero;
  assign Zero = r_zero;

  // Zero flag is updated together with the result it describes
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_zero <= 1'b0;
    end else if (w_run && w_last) begin
      r_zero <= (w_acc_nxt == '0);
    end
  end
`endif

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_cout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_valid) begin
            r_state    <= RUN;
            r_k        <= '0;
            r_in_ready <= 1'b0;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state     <= DONE;
            r_k         <= '0;
            r_res       <= w_acc_nxt;
            r_cout      <= AluCB_out;
            r_out_valid <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (Out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_k         <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Self-checking bench for alu_slice_sequencer: directed corner cases plus
// randomized operations compared against a whole-word arithmetic model.
module tb_alu_slice_sequencer;

  localparam int W_SLICE  = 4;
  localparam int N_SLICES = 4;
  localparam int W        = W_SLICE * N_SLICES;

  logic               Clk = 1'b0;
  logic               nReset;
  logic               In_valid;
  logic               In_ready;
  logic [W-1:0]       OpA, OpB;
  logic               Cin;
  logic [2:0]         OpMode;
  logic [W_SLICE-1:0] AluA, AluB;
  logic               AluCB_in;
  logic [2:0]         AluMode;
  logic [W_SLICE-1:0] AluResult;
  logic               AluCB_out;
  logic               Out_valid;
  logic               Out_ready;
  logic [W-1:0]       Res;
  logic               Cout;
`ifdef ALU_SEQ_ZERO_EN
  logic               Zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] prev_res  = '0;
  logic         prev_cout = 1'b0;

  always #5 Clk = ~Clk;

  alu_slice_sequencer #(.W_SLICE(W_SLICE), .N_SLICES(N_SLICES)) dut (
    .Clk(Clk), .nReset(nReset), .In_valid(In_valid), .In_ready(In_ready),
    .OpA(OpA), .OpB(OpB), .Cin(Cin), .OpMode(OpMode),
    .AluA(AluA), .AluB(AluB), .AluCB_in(AluCB_in), .AluMode(AluMode),
    .AluResult(AluResult), .AluCB_out(AluCB_out),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Res(Res), .Cout(Cout)
`ifdef ALU_SEQ_ZERO_EN
    , .Zero(Zero)
`endif
  );

  // External slice ALU: add, subtract-with-borrow, six bitwise ops (carry = parity)
  logic [W_SLICE:0] alu_t;
  always_comb begin
    alu_t     = '0;
    AluResult = '0;
    AluCB_out = 1'b0;
    case (AluMode)
      3'd0: begin
        alu_t = {1'b0, AluA} + {1'b0, AluB} + {{W_SLICE{1'b0}}, AluCB_in};
        AluResult = alu_t[W_SLICE-1:0];
        AluCB_out = alu_t[W_SLICE];
      end
      3'd1: begin
        alu_t = {1'b0, AluA} - {1'b0, AluB} - {{W_SLICE{1'b0}}, AluCB_in};
        AluResult = alu_t[W_SLICE-1:0];
        AluCB_out = alu_t[W_SLICE];
      end
      3'd2: AluResult = AluA & AluB;
      3'd3: AluResult = AluA | AluB;
      3'd4: AluResult = AluA ^ AluB;
      3'd5: AluResult = ~(AluA & AluB);
      3'd6: AluResult = ~(AluA | AluB);
      default: AluResult = ~(AluA ^ AluB);
    endcase
    if (AluMode > 3'd1) AluCB_out = ^AluResult;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-word reference for the full operation
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [2:0] m,
                                 output logic [W-1:0] r, output logic co);
    logic [W:0] s;
    s = '0;
    r = '0;
    co = 1'b0;
    case (m)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(cin); r = s[W-1:0]; co = s[W]; end
      3'd1: begin s = {1'b0, a} - {1'b0, b} - (W+1)'(cin); r = s[W-1:0]; co = s[W]; end
      default: begin
        case (m)
          3'd2: r = a & b;
          3'd3: r = a | b;
          3'd4: r = a ^ b;
          3'd5: r = ~(a & b);
          3'd6: r = ~(a | b);
          default: r = ~(a ^ b);
        endcase
        co = ^r[W-1:W-W_SLICE];
      end
    endcase
  endfunction

  // Carry/borrow entering slice k, from the low k slices of the operands
  function automatic logic exp_cbin(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic [2:0] m, input int k);
    longint unsigned mask, la, lb;
    if (m > 3'd1) return 1'b0;
    if (k == 0) return cin;
    mask = (64'd1 << (W_SLICE * k)) - 1;
    la = a & mask;
    lb = b & mask;
    if (m == 3'd0) return ((la + lb + cin) >> (W_SLICE * k)) != 0;
    return la < (lb + cin);
  endfunction

  task automatic check_alu_idle(input string tag);
    check({tag, "_alu_a"}, 32'(AluA), 32'd0);
    check({tag, "_alu_b"}, 32'(AluB), 32'd0);
    check({tag, "_alu_cb"}, 32'(AluCB_in), 32'd0);
    check({tag, "_alu_mode"}, 32'(AluMode), 32'd0);
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!In_ready && waited < 20) begin
      @(posedge Clk); #1;
      waited++;
    end
    check("in_ready_wait", 32'(In_ready), 32'd1);
  endtask

  task automatic spam_inputs();
    OpA    = W'($urandom);
    OpB    = W'($urandom);
    Cin    = 1'($urandom);
    OpMode = 3'($urandom);
  endtask

  // One complete transaction; assumes time is just after a rising edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [2:0] m, input int hold, input bit spam);
    logic [W-1:0] er;
    logic         eco;
    ref_op(a, b, cin, m, er, eco);
    wait_ready();
    OpA = a; OpB = b; Cin = cin; OpMode = m;
    In_valid = 1'b1;
    Out_ready = 1'b0;
    @(posedge Clk); #1;
    if (spam) spam_inputs(); else In_valid = 1'b0;
    check("in_ready_run", 32'(In_ready), 32'd0);
    for (int k = 0; k < N_SLICES; k++) begin
      check("alu_a", 32'(AluA), 32'((a >> (W_SLICE * k)) & {W_SLICE{1'b1}}));
      check("alu_b", 32'(AluB), 32'((b >> (W_SLICE * k)) & {W_SLICE{1'b1}}));
      check("alu_mode", 32'(AluMode), 32'(m));
      check("alu_cb_in", 32'(AluCB_in), 32'(exp_cbin(a, b, cin, m, k)));
      check("out_valid_run", 32'(Out_valid), 32'd0);
      check("res_held_run", 32'(Res), 32'(prev_res));
      check("cout_held_run", 32'(Cout), 32'(prev_cout));
      @(posedge Clk); #1;
      if (spam) spam_inputs();
    end
    check("out_valid", 32'(Out_valid), 32'd1);
    check("res", 32'(Res), 32'(er));
    check("cout", 32'(Cout), 32'(eco));
`ifdef ALU_SEQ_ZERO_EN
    check("zero", 32'(Zero), 32'(er == '0));
`endif
    check("in_ready_done", 32'(In_ready), 32'd0);
    check_alu_idle("done");
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk); #1;
      if (spam) spam_inputs();
      check("out_valid_hold", 32'(Out_valid), 32'd1);
      check("res_hold", 32'(Res), 32'(er));
      check("cout_hold", 32'(Cout), 32'(eco));
      check("in_ready_hold", 32'(In_ready), 32'd0);
    end
    In_valid = 1'b0;
    Out_ready = 1'b1;
    @(posedge Clk); #1;
    Out_ready = 1'b0;
    check("out_valid_after", 32'(Out_valid), 32'd0);
    check("in_ready_after", 32'(In_ready), 32'd1);
    check("res_idle", 32'(Res), 32'(er));
    check("cout_idle", 32'(Cout), 32'(eco));
    prev_res  = er;
    prev_cout = eco;
  endtask

  // Reset asserted after the slice-1 capture edge, then a clean operation
  task automatic reset_mid_run();
    wait_ready();
    OpA = 16'h1234; OpB = 16'h0FFF; Cin = 1'b1; OpMode = 3'd0;
    In_valid = 1'b1;
    @(posedge Clk); #1;
    In_valid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("alu_mode_pre_rst", 32'(AluMode), 32'd0);
    nReset = 1'b0;
    #1;
    check("rst_res", 32'(Res), 32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_out_valid", 32'(Out_valid), 32'd0);
    check_alu_idle("rst");
    @(posedge Clk); #1;
    nReset = 1'b1;
    prev_res = '0;
    prev_cout = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rst_no_valid", 32'(Out_valid), 32'd0);
      check("rst_in_ready", 32'(In_ready), 32'd1);
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    nReset = 1'b0;
    In_valid = 1'b0;
    Out_ready = 1'b0;
    OpA = '0; OpB = '0; Cin = 1'b0; OpMode = '0;
    #12;
    check("init_res", 32'(Res), 32'd0);
    check("init_cout", 32'(Cout), 32'd0);
    check("init_out_valid", 32'(Out_valid), 32'd0);
`ifdef ALU_SEQ_ZERO_EN
    check("init_zero", 32'(Zero), 32'd0);
`endif
    check_alu_idle("init");
    @(posedge Clk); #1;
    nReset = 1'b1;
    @(posedge Clk); #1;
    check("init_in_ready", 32'(In_ready), 32'd1);

    run_op(16'h00FF, 16'h0001, 1'b0, 3'd0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 3'd0, 0, 1'b0);
    run_op(16'h0100, 16'h0001, 1'b0, 3'd1, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 3'd1, 0, 1'b0);
    run_op(16'hA5C3, 16'h3C5A, 1'b1, 3'd0, 3, 1'b0);
    run_op(16'h1357, 16'h2468, 1'b0, 3'd4, 1, 1'b1);
    reset_mid_run();
    run_op(16'h7FFF, 16'h8000, 1'b1, 3'd1, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 3'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
